fetch_queue: RTL and testbench

Parametrised instruction-fetch stage: a PC generator plus a DEPTH-entry prefetch queue that decouples icache fetch from decode stalls. Sits between the icache (imem request/ihit) and the IF/ID latch. Replaces the single-PC fetch with buffered fetch, a ready/valid handshake to decode, and redirect-with-flush. One instance per core; the per-core boot address comes in on init.

---
 rtl/fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: a PC generator feeding a DEPTH-entry prefetch queue that
// decouples icache fetches from decode stalls, with a ready/valid head and redirect-with-flush.
// Latency: an instruction accepted on ihit appears at the head one cycle later (no bypass).
// Backpressure: imemREN drops when the queue is full or a redirect is in progress.
//
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   init                       boot PC, loaded into the fetch PC while nRST is low
//   imemREN/imemaddr           icache read request and fetch address (the fetch PC)
//   ihit/imemload              icache hit and returned instruction word
//   redirect/redirect_addr     flush the queue and restart fetch at redirect_addr
//   deq_ready                  decode consumes the head entry this cycle
//   instr_valid/instr/
//   instr_pc/instr_npc         head entry: valid, instruction, PC and PC+PC_INC
//   count                      occupied entries
// Optional build macro FETCH_PERF_EN adds saturating 32-bit counters
//   fetch_cnt / miss_cnt / flush_cnt.
module fetch_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int PC_INC = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [WORD_W-1:0]            init,
  output logic                         imemREN,
  output logic [WORD_W-1:0]            imemaddr,
  input  logic                         ihit,
  input  logic [WORD_W-1:0]            imemload,
  input  logic                         redirect,
  input  logic [WORD_W-1:0]            redirect_addr,
  input  logic                         deq_ready,
  output logic                         instr_valid,
  output logic [WORD_W-1:0]            instr,
  output logic [WORD_W-1:0]            instr_pc,
  output logic [WORD_W-1:0]            instr_npc,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                  fetch_cnt,
  output logic [31:0]                  miss_cnt,
  output logic [31:0]                  flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [WORD_W-1:0] instr_mem_q [DEPTH];
  logic [WORD_W-1:0] instr_mem_d [DEPTH];
  logic [WORD_W-1:0] pc_mem_q    [DEPTH];
  logic [WORD_W-1:0] pc_mem_d    [DEPTH];
  logic [WORD_W-1:0] npc_mem_q   [DEPTH];
  logic [WORD_W-1:0] npc_mem_d   [DEPTH];

  logic full;
  logic enq;
  logic deq;
  logic [WORD_W-1:0] pc_inc;

  assign full   = (count_q == CW'(DEPTH));
  assign pc_inc = pc_q + WORD_W'(PC_INC);

  // Both handshakes are gated by nRST so nothing is requested or presented in reset.
  assign imemREN     = nRST && !full && !redirect;
  assign instr_valid = nRST && (count_q != '0) && !redirect;
  assign enq         = imemREN && ihit;
  assign deq         = instr_valid && deq_ready;

  assign imemaddr  = pc_q;
  assign instr     = instr_mem_q[head_q];
  assign instr_pc  = pc_mem_q[head_q];
  assign instr_npc = npc_mem_q[head_q];
  assign count     = count_q;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    npc_mem_d   = npc_mem_q;

    if (redirect) begin
      // Queue contents are abandoned; storage is left as-is since it is unreachable.
      pc_d    = redirect_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        instr_mem_d[tail_q] = imemload;
        pc_mem_d[tail_q]    = pc_q;
        npc_mem_d[tail_q]   = pc_inc;
        tail_d              = ptr_next(tail_q);
        pc_d                = pc_inc;
      end
      if (deq) begin
        head_d = ptr_next(head_q);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q    <= init;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
        npc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
      npc_mem_q   <= npc_mem_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] miss_cnt_q,  miss_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    fetch_cnt_d = sat_inc(fetch_cnt_q, enq);
    miss_cnt_d  = sat_inc(miss_cnt_q, imemREN && !ihit);
    // Only redirects that actually discard queued entries count as flushes.
    flush_cnt_d = sat_inc(flush_cnt_q, redirect && (count_q != '0));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_q <= '0;
      miss_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a DEPTH=4 instance for fill/miss/redirect/reset
// sequences and a DEPTH=3 instance for pointer wrap under continuous fetch.
module tb_fetch_queue;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] init;

  logic        ihit, redirect, deq_ready;
  logic [31:0] imemload, redirect_addr;
  logic        imemREN, instr_valid;
  logic [31:0] imemaddr, instr, instr_pc, instr_npc;
  logic [2:0]  count;

  logic        d3_ihit, d3_redirect, d3_deq_ready;
  logic [31:0] d3_imemload, d3_redirect_addr;
  logic        d3_imemREN, d3_instr_valid;
  logic [31:0] d3_imemaddr, d3_instr, d3_instr_pc, d3_instr_npc;
  logic [1:0]  d3_count;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, miss_cnt, flush_cnt;
  logic [31:0] d3_fetch_cnt, d3_miss_cnt, d3_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_pc;

  always #5 CLK = ~CLK;

  // Icache model: instruction word is a fixed function of its address.
  assign imemload    = imemaddr ^ K;
  assign d3_imemload = d3_imemaddr ^ K;

  fetch_queue #(.WORD_W(32), .DEPTH(4), .PC_INC(4)) u4 (
    .CLK(CLK), .nRST(nRST), .init(init),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .redirect(redirect), .redirect_addr(redirect_addr), .deq_ready(deq_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_npc(instr_npc), .count(count)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .miss_cnt(miss_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_queue #(.WORD_W(32), .DEPTH(3), .PC_INC(4)) u3 (
    .CLK(CLK), .nRST(nRST), .init(init),
    .imemREN(d3_imemREN), .imemaddr(d3_imemaddr), .ihit(d3_ihit), .imemload(d3_imemload),
    .redirect(d3_redirect), .redirect_addr(d3_redirect_addr), .deq_ready(d3_deq_ready),
    .instr_valid(d3_instr_valid), .instr(d3_instr), .instr_pc(d3_instr_pc),
    .instr_npc(d3_instr_npc), .count(d3_count)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(d3_fetch_cnt), .miss_cnt(d3_miss_cnt), .flush_cnt(d3_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    init = 32'h0000_0200;
    ihit = 1'b1; redirect = 1'b0; redirect_addr = '0; deq_ready = 1'b0;
    d3_ihit = 1'b0; d3_redirect = 1'b0; d3_redirect_addr = '0; d3_deq_ready = 1'b0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #2;
    // In reset
    chk("rst_imemREN", {31'd0, imemREN}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_addr", imemaddr, 32'h200);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_npc", instr_npc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    tick();
    tick();
    nRST = 1'b1;
    #1;

    // Fill the queue: four sequential fetches with decode stalled
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr", imemaddr, 32'h200 + 32'(4 * i));
      chk("fill_count", {29'd0, count}, 32'(i));
      chk("fill_ren", {31'd0, imemREN}, 32'd1);
      tick();
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ren", {31'd0, imemREN}, 32'd0);
    chk("full_addr", imemaddr, 32'h210);
    chk("full_instr", instr, 32'h200 ^ K);
    chk("full_instr_pc", instr_pc, 32'h200);
    chk("full_instr_npc", instr_npc, 32'h204);

    // One dequeue from full
    deq_ready = 1'b1;
    #1;
    chk("full_deq_valid", {31'd0, instr_valid}, 32'd1);
    chk("full_deq_ren", {31'd0, imemREN}, 32'd0);
    tick();
    deq_ready = 1'b0;
    ihit = 1'b0;
    #1;
    chk("after_deq_count", {29'd0, count}, 32'd3);
    chk("after_deq_ren", {31'd0, imemREN}, 32'd1);
    chk("after_deq_addr", imemaddr, 32'h210);

    // Drain: order preserved
    deq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
      chk("drain_pc", instr_pc, 32'h204 + 32'(4 * k));
      chk("drain_npc", instr_npc, 32'h208 + 32'(4 * k));
      chk("drain_instr", instr, (32'h204 + 32'(4 * k)) ^ K);
      tick();
    end
    chk("empty_valid", {31'd0, instr_valid}, 32'd0);
    chk("empty_count", {29'd0, count}, 32'd0);

    // Redirect to 0x300 from an empty queue, then a three-cycle miss
    deq_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h300;
    #1;
    chk("redir_ren_low", {31'd0, imemREN}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("miss_addr", imemaddr, 32'h300);
      chk("miss_ren", {31'd0, imemREN}, 32'd1);
      chk("miss_count", {29'd0, count}, 32'd0);
      tick();
    end
    ihit = 1'b1;
    tick();
    chk("miss_done_count", {29'd0, count}, 32'd1);
    chk("miss_done_pc", instr_pc, 32'h300);
    chk("miss_done_addr", imemaddr, 32'h304);

    // Redirect with three entries queued and a hit in the same cycle
    tick();
    tick();
    chk("pre_redir_count", {29'd0, count}, 32'd3);
    chk("pre_redir_addr", imemaddr, 32'h30C);
    redirect = 1'b1; redirect_addr = 32'h1000; deq_ready = 1'b1;
    #1;
    chk("redir_ren", {31'd0, imemREN}, 32'd0);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0; deq_ready = 1'b0; ihit = 1'b0;
    #1;
    chk("post_redir_count", {29'd0, count}, 32'd0);
    chk("post_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_redir_addr", imemaddr, 32'h1000);
    ihit = 1'b1;
    tick();
    chk("redir_first_pc", instr_pc, 32'h1000);
    chk("redir_first_instr", instr, 32'h1000 ^ K);
    chk("redir_first_count", {29'd0, count}, 32'd1);

    // Reset asserted during a miss
    ihit = 1'b0;
    nRST = 1'b0;
    #1;
    chk("midrst_ren", {31'd0, imemREN}, 32'd0);
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_addr", imemaddr, 32'h200);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
`endif
    tick();
    nRST = 1'b1;
    #1;

    // Five hits with decode draining, two miss cycles, one redirect with a non-empty queue
    ihit = 1'b1; deq_ready = 1'b1;
    for (int h = 0; h < 5; h++) tick();
    chk("perf_seq_count", {29'd0, count}, 32'd1);
    chk("perf_seq_pc", instr_pc, 32'h210);
    chk("perf_seq_addr", imemaddr, 32'h214);
    ihit = 1'b0; deq_ready = 1'b0;
    tick();
    tick();
    chk("perf_miss_addr", imemaddr, 32'h214);
    redirect = 1'b1; redirect_addr = 32'h2000;
    tick();
    redirect = 1'b0;
    #1;
    chk("perf_redir_addr", imemaddr, 32'h2000);
    chk("perf_redir_count", {29'd0, count}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", fetch_cnt, 32'd5);
    chk("perf_miss_cnt", miss_cnt, 32'd2);
    chk("perf_flush_cnt", flush_cnt, 32'd1);
    nRST = 1'b0;
    #1;
    chk("perf_clr_fetch", fetch_cnt, 32'd0);
    chk("perf_clr_miss", miss_cnt, 32'd0);
    chk("perf_clr_flush", flush_cnt, 32'd0);
    tick();
    nRST = 1'b1;
    #1;
`endif

    // DEPTH=3: continuous fetch and dequeue, pointers wrap repeatedly
    d3_ihit = 1'b1; d3_deq_ready = 1'b1;
    exp_pc = 32'h200;
    #1;
    chk("d3_start_addr", d3_imemaddr, 32'h200);
    for (int i = 0; i < 20; i++) begin
      chk("d3_valid", {31'd0, d3_instr_valid}, (i != 0) ? 32'd1 : 32'd0);
      if (d3_instr_valid) begin
        chk("d3_pc_seq", d3_instr_pc, exp_pc);
        chk("d3_instr_seq", d3_instr, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    chk("d3_end_count", {30'd0, d3_count}, 32'd1);
    chk("d3_end_pc", d3_instr_pc, 32'h24C);
    d3_deq_ready = 1'b0;
    tick();
    tick();
    chk("d3_full_count", {30'd0, d3_count}, 32'd3);
    chk("d3_full_ren", {31'd0, d3_imemREN}, 32'd0);
    chk("d3_full_pc", d3_instr_pc, 32'h24C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
